// File: rtl/timer_keypad_entry.sv
// Keypad-to-timer entry: debounce, priority-encode and shift BCD digits (MM..M:SS), plus total seconds.
// Optional macro TIMER_ENTRY_SEC_CLAMP_EN clamps the seconds pair to 59 inside total_seconds only.
module timer_keypad_entry #(
  parameter int NUM_DIGITS      = 4,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic                    clear,
  input  logic [9:0]              switches,
  output logic [4*NUM_DIGITS-1:0] digits,
  output logic [2:0]              digit_count,
  output logic                    key_strobe,
  output logic [3:0]              key_code,
  output logic                    entry_valid,
  output logic                    full,
  output logic [15:0]             total_seconds
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, DEBOUNCE, HELD} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [3:0]       cap_code, cap_nxt;
  logic [3:0]       enc_code;
  logic             key_any;
  logic             accept;
  logic [15:0]      sec_bin, min_bin, total_nxt;

  // Highest pressed index wins.
  always_comb begin
    enc_code = 4'd0;
    for (int i = 0; i < 10; i++) begin
      if (switches[i]) enc_code = 4'(i);
    end
    key_any = |switches;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= HELD;
      cnt      <= '0;
      cap_code <= 4'd0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      cap_code <= cap_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    cap_nxt   = cap_code;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        if (key_any) begin
          cap_nxt = enc_code;
          cnt_nxt = CNT_W'(1);
          if (DEBOUNCE_CYCLES == 1) begin
            accept    = 1'b1;
            state_nxt = HELD;
          end else begin
            state_nxt = DEBOUNCE;
          end
        end
      end
      DEBOUNCE: begin
        if (!key_any || enc_code != cap_code) begin
          state_nxt = IDLE;
        end else begin
          cnt_nxt = cnt + 1'b1;
          if (cnt_nxt == CNT_W'(DEBOUNCE_CYCLES)) begin
            accept    = 1'b1;
            state_nxt = HELD;
          end
        end
      end
      HELD: begin
        if (!key_any) state_nxt = IDLE;
      end
      default: state_nxt = HELD;
    endcase
    // Disabled entry parks in HELD so a key pressed meanwhile needs a full release.
    if (!enable) begin
      state_nxt = HELD;
      accept    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      digits      <= '0;
      digit_count <= 3'd0;
      key_code    <= 4'd0;
      key_strobe  <= 1'b0;
    end else begin
      key_strobe <= 1'b0;
      if (clear) begin
        digits      <= '0;
        digit_count <= 3'd0;
        key_code    <= 4'd0;
      end else if (accept && !full && !(enc_code == 4'd0 && digit_count == 3'd0)) begin
        digits      <= {digits[4*NUM_DIGITS-5:0], enc_code};
        digit_count <= digit_count + 3'd1;
        key_code    <= enc_code;
        key_strobe  <= 1'b1;
      end
    end
  end

  assign entry_valid = (digit_count != 3'd0);
  assign full        = (digit_count == 3'(NUM_DIGITS));

  always_comb begin
    sec_bin = 16'(digits[7:4]) * 16'd10 + 16'(digits[3:0]);
`ifdef TIMER_ENTRY_SEC_CLAMP_EN
    if (sec_bin > 16'd59) sec_bin = 16'd59;
`else
    sec_bin = sec_bin;
`endif
    min_bin = 16'd0;
    for (int i = NUM_DIGITS - 1; i >= 2; i--) begin
      min_bin = min_bin * 16'd10 + 16'(digits[4*i +: 4]);
    end
    total_nxt = min_bin * 16'd60 + sec_bin;
  end

  always_ff @(posedge clk) begin
    if (rst) total_seconds <= 16'd0;
    else     total_seconds <= total_nxt;
  end

endmodule

// File: tb/tb_timer_keypad_entry.sv
// Scoreboard bench for timer_keypad_entry (NUM_DIGITS=4, DEBOUNCE_CYCLES=4).
module tb_timer_keypad_entry;
  localparam int N = 4;
  localparam int D = 4;

  logic        clk = 1'b0;
  logic        rst, enable, clear;
  logic [9:0]  switches;
  logic [15:0] digits;
  logic [2:0]  digit_count;
  logic        key_strobe;
  logic [3:0]  key_code;
  logic        entry_valid, full;
  logic [15:0] total_seconds;

  timer_keypad_entry #(.NUM_DIGITS(N), .DEBOUNCE_CYCLES(D)) dut (
    .clk(clk), .rst(rst), .enable(enable), .clear(clear), .switches(switches),
    .digits(digits), .digit_count(digit_count), .key_strobe(key_strobe),
    .key_code(key_code), .entry_valid(entry_valid), .full(full),
    .total_seconds(total_seconds)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] dig;
    logic [3:0]  code;
  } exp_t;

  exp_t        exp_q[$];
  int          n_checks = 0;
  int          n_pass = 0;
  logic        mon_on = 1'b0;
  logic [15:0] m_dig = 16'd0;
  int          m_cnt = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Every strobe must match the next expected entry.
  always @(negedge clk) begin
    exp_t e;
    if (mon_on && key_strobe) begin
      if (exp_q.size() == 0) begin
        check("unexpected_strobe", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("strobe_digits", 32'(digits), 32'(e.dig));
        check("strobe_code", 32'(key_code), 32'(e.code));
      end
    end
  end

  task automatic model_accept(input int d);
    if (m_cnt < N && !(d == 0 && m_cnt == 0)) begin
      m_dig = {m_dig[11:0], 4'(d)};
      m_cnt++;
      exp_q.push_back(exp_t'{dig: m_dig, code: 4'(d)});
    end
  endtask

  task automatic press(input int d, input int n);
    if (n >= D) model_accept(d);
    @(negedge clk) switches = 10'd1 << d;
    repeat (n) @(posedge clk);
    @(negedge clk) switches = 10'd0;
    repeat (2) @(posedge clk);
  endtask

  task automatic do_clear();
    @(negedge clk) clear = 1'b1;
    @(posedge clk);
    @(negedge clk) clear = 1'b0;
    m_dig = 16'd0;
    m_cnt = 0;
  endtask

  initial begin
    rst = 1'b1; enable = 1'b1; clear = 1'b0; switches = 10'h080;
    repeat (3) @(posedge clk);
    mon_on = 1'b1;
    @(negedge clk);
    check("rst_digits", 32'(digits), 32'd0);
    check("rst_count", 32'(digit_count), 32'd0);
    check("rst_strobe", 32'(key_strobe), 32'd0);
    check("rst_code", 32'(key_code), 32'd0);
    check("rst_valid", 32'(entry_valid), 32'd0);
    check("rst_full", 32'(full), 32'd0);
    check("rst_total", 32'(total_seconds), 32'd0);
    rst = 1'b0;
    repeat (6) @(posedge clk);
    @(negedge clk) switches = 10'd0;
    check("held_thru_reset", 32'(digits), 32'd0);
    repeat (2) @(posedge clk);
    press(7, 6);
    check("t1_digits", 32'(digits), 32'h0007);
    check("t1_total", 32'(total_seconds), 32'd7);

    // Short press, then a mid-debounce code change: neither is accepted.
    do_clear();
    press(3, D - 1);
    check("short_press", 32'(digits), 32'd0);
    @(negedge clk) switches = 10'd1 << 2;
    repeat (2) @(posedge clk);
    @(negedge clk) switches = 10'd1 << 4;
    repeat (2) @(posedge clk);
    @(negedge clk) switches = 10'd0;
    repeat (2) @(posedge clk);
    check("code_change", 32'(digits), 32'd0);
    model_accept(3);
    @(negedge clk) switches = 10'd1 << 3;
    repeat (D - 1) @(posedge clk);
    @(negedge clk) check("strobe_early", 32'(key_strobe), 32'd0);
    @(posedge clk);
    @(negedge clk);
    check("strobe_on_time", 32'(key_strobe), 32'd1);
    check("t2_digits", 32'(digits), 32'h0003);
    check("total_lag", 32'(total_seconds), 32'd0);
    @(negedge clk);
    check("strobe_one_cycle", 32'(key_strobe), 32'd0);
    check("t2_total", 32'(total_seconds), 32'd3);
    switches = 10'd0;
    repeat (2) @(posedge clk);

    // Leading zero ignored.
    do_clear();
    press(0, D + 1); press(1, D); press(3, D + 2); press(0, D);
    check("t3_digits", 32'(digits), 32'h0130);
    check("t3_count", 32'(digit_count), 32'd3);
    check("t3_total", 32'(total_seconds), 32'd90);
    check("t3_valid", 32'(entry_valid), 32'd1);
    check("t3_full", 32'(full), 32'd0);

    // Fifth digit into a full register is dropped.
    do_clear();
    press(1, D); press(2, D); press(3, D); press(4, D); press(5, D + 1);
    check("t4_digits", 32'(digits), 32'h1234);
    check("t4_full", 32'(full), 32'd1);
    check("t4_code", 32'(key_code), 32'd4);
    check("t4_total", 32'(total_seconds), 32'd754);

    do_clear();
    press(1, D); press(9, D); press(9, D);
`ifdef TIMER_ENTRY_SEC_CLAMP_EN
    check("t5_total", 32'(total_seconds), 32'd119);
`else
    check("t5_total", 32'(total_seconds), 32'd159);
`endif
    // Clear on the accepting edge wins; the key stays latched until release.
    @(negedge clk) switches = 10'd1 << 2;
    repeat (D - 1) @(posedge clk);
    @(negedge clk) clear = 1'b1;
    @(posedge clk);
    @(negedge clk) clear = 1'b0;
    m_dig = 16'd0;
    m_cnt = 0;
    check("clr_digits", 32'(digits), 32'd0);
    check("clr_count", 32'(digit_count), 32'd0);
    check("clr_code", 32'(key_code), 32'd0);
    check("clr_strobe", 32'(key_strobe), 32'd0);
    check("clr_valid", 32'(entry_valid), 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("clr_total", 32'(total_seconds), 32'd0);
    check("clr_no_reaccept", 32'(digits), 32'd0);
    switches = 10'd0;
    repeat (2) @(posedge clk);

    // Multiple switches: highest index wins.
    model_accept(5);
    @(negedge clk) switches = 10'b0000100101;
    repeat (D + 2) @(posedge clk);
    @(negedge clk) switches = 10'd0;
    repeat (2) @(posedge clk);
    check("enc_code", 32'(key_code), 32'd5);
    check("enc_digits", 32'(digits), 32'h0005);

    // Disable mid-press: nothing accepted until the key is released.
    @(negedge clk) switches = 10'd1 << 6;
    repeat (2) @(posedge clk);
    @(negedge clk) enable = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk) enable = 1'b1;
    repeat (8) @(posedge clk);
    @(negedge clk) check("en_blocked", 32'(digits), 32'h0005);
    switches = 10'd0;
    repeat (2) @(posedge clk);
    press(6, D);
    check("en_after_release", 32'(digits), 32'h0056);
    check("en_code", 32'(key_code), 32'd6);

    repeat (2) @(posedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
